// File: rtl/temporizador_irrigacao_if.sv
// Signal bundle for the irrigation timer: control strobes and zone masks in,
// BCD countdown, valve drive and multiplexed display out.
interface temporizador_irrigacao_if #(
  parameter int NUM_ZONAS = 4
);
  logic                 umSegundo;
  logic                 displayClock;
  logic                 iniciar;
  logic                 parar;
  logic                 pausa;
  logic [NUM_ZONAS-1:0] habilitaZona;
  logic [NUM_ZONAS-1:0] modoZona;

  logic [3:0]           dezenaMinuto;
  logic [3:0]           unidadeMinuto;
  logic [3:0]           dezenaSegundos;
  logic [3:0]           unidadeSegundos;
  logic [NUM_ZONAS-1:0] valvula;
  logic                 aspersaoAtiva;
  logic [2:0]           zonaAtiva;
  logic                 ocupado;
  logic                 fim;
  logic [3:0]           displayDigits;
  logic [7:0]           displaySegments;

  modport master (
    output umSegundo, displayClock, iniciar, parar, pausa, habilitaZona, modoZona,
    input  dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos,
    input  valvula, aspersaoAtiva, zonaAtiva, ocupado, fim,
    input  displayDigits, displaySegments
  );

  modport slave (
    input  umSegundo, displayClock, iniciar, parar, pausa, habilitaZona, modoZona,
    output dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos,
    output valvula, aspersaoAtiva, zonaAtiva, ocupado, fim,
    output displayDigits, displaySegments
  );
endinterface

// File: rtl/temporizador_irrigacao.sv
// Multi-zone irrigation sequencer: waters each enabled zone in ascending order,
// counting a BCD mm:ss value down on the one-second enable, with a 4-digit scan display.
module temporizador_irrigacao #(
  parameter int NUM_ZONAS              = 4,   // legal range 2..8
  parameter int PRESET_ASPERSAO_MIN    = 51,  // 1..59
  parameter int PRESET_GOTEJAMENTO_MIN = 3    // 1..59
) (
  input logic                     clock,
  input logic                     resetN,
  temporizador_irrigacao_if.slave bus
);

  localparam int IDX_W = (NUM_ZONAS > 2) ? $clog2(NUM_ZONAS) : 1;

  localparam logic [3:0] ASP_DEZ = 4'(PRESET_ASPERSAO_MIN / 10);
  localparam logic [3:0] ASP_UNI = 4'(PRESET_ASPERSAO_MIN % 10);
  localparam logic [3:0] GOT_DEZ = 4'(PRESET_GOTEJAMENTO_MIN / 10);
  localparam logic [3:0] GOT_UNI = 4'(PRESET_GOTEJAMENTO_MIN % 10);

  typedef enum logic [2:0] {
    OCIOSO,
    PROXIMA,
    CONTANDO,
    PAUSADO,
    CONCLUIDO
  } estado_t;

  typedef struct packed {
    logic [3:0] dm;
    logic [3:0] um;
    logic [3:0] ds;
    logic [3:0] us;
  } bcd_t;

  localparam bcd_t UM_SEGUNDO = '{dm: 4'd0, um: 4'd0, ds: 4'd0, us: 4'd1};

  estado_t              estado, estado_prox;
  bcd_t                 tempo, tempo_prox, tempo_dec;
  logic [NUM_ZONAS-1:0] pendente, pendente_prox;
  logic [NUM_ZONAS-1:0] modo_lat;
  logic [NUM_ZONAS-1:0] valvula, valvula_prox;
  logic [IDX_W-1:0]     zona, zona_prox, indice;
  logic                 achou;
  logic                 carregar, decrementar, limpar, iniciar_seq;
  logic                 aspersao, aspersao_prox;
  logic                 ocupado, ocupado_prox;
  logic                 fim, fim_prox;
  logic [1:0]           scan;
  logic [3:0]           digito;

  function automatic bcd_t preset(input logic asp);
    return asp ? bcd_t'({ASP_DEZ, ASP_UNI, 8'h00}) : bcd_t'({GOT_DEZ, GOT_UNI, 8'h00});
  endfunction

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 are blank.
  function automatic logic [6:0] glifo(input logic [3:0] valor);
    case (valor)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Pending zones are cleared as they are served, so the lowest set bit is the
  // lowest enabled zone above the last one watered.
  always_comb begin
    achou  = 1'b0;
    indice = '0;
    for (int i = NUM_ZONAS - 1; i >= 0; i--) begin
      if (pendente[i]) begin
        achou  = 1'b1;
        indice = IDX_W'(i);
      end
    end
  end

  always_comb begin
    tempo_dec = tempo;
    if (tempo.us != 4'd0) begin
      tempo_dec.us = tempo.us - 4'd1;
    end else begin
      tempo_dec.us = 4'd9;
      if (tempo.ds != 4'd0) begin
        tempo_dec.ds = tempo.ds - 4'd1;
      end else begin
        tempo_dec.ds = 4'd5;
        if (tempo.um != 4'd0) begin
          tempo_dec.um = tempo.um - 4'd1;
        end else begin
          tempo_dec.um = 4'd9;
          tempo_dec.dm = tempo.dm - 4'd1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    estado_prox = estado;
    carregar    = 1'b0;
    decrementar = 1'b0;
    limpar      = 1'b0;
    iniciar_seq = 1'b0;

    case (estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          iniciar_seq = 1'b1;
          estado_prox = PROXIMA;
        end
      end
      PROXIMA: begin
        if (achou) begin
          carregar    = 1'b1;
          estado_prox = CONTANDO;
        end else begin
          estado_prox = CONCLUIDO;
        end
      end
      CONTANDO: begin
        if (bus.pausa) begin
          estado_prox = PAUSADO;
        end else if (bus.umSegundo) begin
          decrementar = 1'b1;
          if (tempo == UM_SEGUNDO) estado_prox = PROXIMA;
        end
      end
      PAUSADO: begin
        if (!bus.pausa) estado_prox = CONTANDO;
      end
      CONCLUIDO: estado_prox = OCIOSO;
      default:   estado_prox = OCIOSO;
    endcase

    // Cancel overrides everything, including a simultaneous start.
    if (bus.parar) begin
      estado_prox = OCIOSO;
      limpar      = 1'b1;
      carregar    = 1'b0;
      decrementar = 1'b0;
      iniciar_seq = 1'b0;
    end
  end

  // Outputs are computed from the next state so they change on the same edge as the state.
  always_comb begin
    tempo_prox    = tempo;
    pendente_prox = pendente;
    zona_prox     = zona;

    if (limpar) begin
      tempo_prox = '0;
      zona_prox  = '0;
    end else if (iniciar_seq) begin
      pendente_prox = bus.habilitaZona;
    end else if (carregar) begin
      tempo_prox            = preset(modo_lat[indice]);
      pendente_prox[indice] = 1'b0;
      zona_prox             = indice;
    end else if (decrementar) begin
      tempo_prox = tempo_dec;
    end

    valvula_prox  = '0;
    aspersao_prox = 1'b0;
    if (estado_prox == CONTANDO) begin
      valvula_prox[zona_prox] = 1'b1;
      aspersao_prox           = modo_lat[zona_prox];
    end

    ocupado_prox = (estado_prox == PROXIMA) || (estado_prox == CONTANDO) ||
                   (estado_prox == PAUSADO);
    fim_prox     = (estado_prox == CONCLUIDO);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      estado   <= OCIOSO;
      tempo    <= '0;
      pendente <= '0;
      modo_lat <= '0;
      zona     <= '0;
      valvula  <= '0;
      aspersao <= 1'b0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      estado   <= estado_prox;
      tempo    <= tempo_prox;
      pendente <= pendente_prox;
      if (iniciar_seq) modo_lat <= bus.modoZona;
      zona     <= zona_prox;
      valvula  <= valvula_prox;
      aspersao <= aspersao_prox;
      ocupado  <= ocupado_prox;
      fim      <= fim_prox;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      scan <= 2'd0;
    end else if (bus.displayClock) begin
      scan <= scan + 2'd1;
    end
  end

  always_comb begin
    case (scan)
      2'd0:    digito = tempo.us;
      2'd1:    digito = tempo.ds;
      2'd2:    digito = tempo.um;
      default: digito = tempo.dm;
    endcase
  end

  assign bus.dezenaMinuto    = tempo.dm;
  assign bus.unidadeMinuto   = tempo.um;
  assign bus.dezenaSegundos  = tempo.ds;
  assign bus.unidadeSegundos = tempo.us;
  assign bus.valvula         = valvula;
  assign bus.aspersaoAtiva   = aspersao;
  assign bus.zonaAtiva       = 3'(zona);
  assign bus.ocupado         = ocupado;
  assign bus.fim             = fim;

  // The decimal point on the minutes-units digit separates mm.ss.
  assign bus.displayDigits   = ~(4'b0001 << scan);
  assign bus.displaySegments = {(scan != 2'd2), glifo(digito)};

endmodule

// File: tb/tb_temporizador_irrigacao.sv
// Directed bench for the irrigation timer: one instance with short presets for
// sequencing, a second with 10/13 minute presets for borrow chain and display.
module tb_temporizador_irrigacao;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  temporizador_irrigacao_if #(.NUM_ZONAS(4)) bus_a ();
  temporizador_irrigacao_if #(.NUM_ZONAS(4)) bus_b ();

  temporizador_irrigacao #(
    .NUM_ZONAS(4), .PRESET_ASPERSAO_MIN(2), .PRESET_GOTEJAMENTO_MIN(1)
  ) dut (
    .clock(clock), .resetN(resetN), .bus(bus_a)
  );

  temporizador_irrigacao #(
    .NUM_ZONAS(4), .PRESET_ASPERSAO_MIN(13), .PRESET_GOTEJAMENTO_MIN(10)
  ) dut_b (
    .clock(clock), .resetN(resetN), .bus(bus_b)
  );

  typedef struct {
    logic        tick;
    logic        pausa;
    logic [15:0] bcd;
    logic [3:0]  valv;
  } vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
  } disp_t;

  int checks    = 0;
  int errors    = 0;
  int fim_count = 0;

  always @(negedge clock) if (bus_a.fim === 1'b1) fim_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] bcd_a();
    return {bus_a.dezenaMinuto, bus_a.unidadeMinuto, bus_a.dezenaSegundos, bus_a.unidadeSegundos};
  endfunction

  function automatic logic [15:0] bcd_b();
    return {bus_b.dezenaMinuto, bus_b.unidadeMinuto, bus_b.dezenaSegundos, bus_b.unidadeSegundos};
  endfunction

  task automatic tick_a();
    bus_a.umSegundo = 1'b1;
    cycle();
    bus_a.umSegundo = 1'b0;
    repeat (3) cycle();
  endtask

  // Ticks every 4 clocks while the expected valve stays open; returns tick count.
  task automatic run_zone(input logic [3:0] v_exp, input logic a_exp,
                          output int n, output logic asp_ok);
    n      = 0;
    asp_ok = 1'b1;
    while (bus_a.valvula == v_exp && n < 400) begin
      if (bus_a.aspersaoAtiva !== a_exp) asp_ok = 1'b0;
      bus_a.umSegundo = 1'b1;
      cycle();
      bus_a.umSegundo = 1'b0;
      n++;
      if (bus_a.valvula == v_exp) repeat (3) cycle();
    end
  endtask

  initial begin
    vec_t  vetores [7];
    disp_t telas   [5];
    int    n;
    logic  asp_ok;
    logic  hold_ok;

    vetores[0] = '{1'b1, 1'b0, 16'h0159, 4'b0001};
    vetores[1] = '{1'b0, 1'b0, 16'h0159, 4'b0001};
    vetores[2] = '{1'b1, 1'b0, 16'h0158, 4'b0001};
    vetores[3] = '{1'b1, 1'b1, 16'h0158, 4'b0000};
    vetores[4] = '{1'b1, 1'b1, 16'h0158, 4'b0000};
    vetores[5] = '{1'b1, 1'b0, 16'h0158, 4'b0001};
    vetores[6] = '{1'b1, 1'b0, 16'h0157, 4'b0001};

    telas[0] = '{4'b1110, 8'h99};
    telas[1] = '{4'b1101, 8'hB0};
    telas[2] = '{4'b1011, 8'h24};
    telas[3] = '{4'b0111, 8'hF9};
    telas[4] = '{4'b1110, 8'h99};

    bus_a.umSegundo = 0; bus_a.displayClock = 0; bus_a.iniciar = 0; bus_a.parar = 0;
    bus_a.pausa = 0; bus_a.habilitaZona = '0; bus_a.modoZona = '0;
    bus_b.umSegundo = 0; bus_b.displayClock = 0; bus_b.iniciar = 0; bus_b.parar = 0;
    bus_b.pausa = 0; bus_b.habilitaZona = '0; bus_b.modoZona = '0;

    repeat (2) cycle();
    check("reset bcd", bcd_a(), 16'h0000);
    check("reset valvula", bus_a.valvula, 4'b0000);
    check("reset ocupado", bus_a.ocupado, 1'b0);
    check("reset fim", bus_a.fim, 1'b0);
    check("reset zona", bus_a.zonaAtiva, 3'd0);
    check("reset aspersao", bus_a.aspersaoAtiva, 1'b0);
    check("reset digits", bus_a.displayDigits, 4'b1110);
    check("reset segments", bus_a.displaySegments, 8'hC0);
    resetN = 1'b1;
    cycle();

    // Full sequence: mask 1011, zone 0 sprinkler.
    bus_a.habilitaZona = 4'b1011;
    bus_a.modoZona     = 4'b0001;
    bus_a.iniciar      = 1'b1;
    cycle();
    bus_a.iniciar      = 1'b0;
    check("start proxima ocupado", bus_a.ocupado, 1'b1);
    check("start proxima valvula", bus_a.valvula, 4'b0000);
    bus_a.habilitaZona = 4'b0100;
    bus_a.modoZona     = 4'b1111;
    cycle();
    check("start valvula", bus_a.valvula, 4'b0001);
    check("start bcd 02:00", bcd_a(), 16'h0200);
    check("start aspersao", bus_a.aspersaoAtiva, 1'b1);
    check("start zona", bus_a.zonaAtiva, 3'd0);

    for (int i = 0; i < 7; i++) begin
      bus_a.umSegundo = vetores[i].tick;
      bus_a.pausa     = vetores[i].pausa;
      cycle();
      check($sformatf("vec%0d bcd", i), bcd_a(), vetores[i].bcd);
      check($sformatf("vec%0d valvula", i), bus_a.valvula, vetores[i].valv);
    end
    bus_a.umSegundo = 1'b0;
    bus_a.pausa     = 1'b0;

    repeat (27) tick_a();
    check("reach 01:30", bcd_a(), 16'h0130);
    bus_a.pausa = 1'b1;
    cycle();
    check("pause valvula", bus_a.valvula, 4'b0000);
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick_a();
      if (bus_a.valvula !== 4'b0000 || bcd_a() !== 16'h0130) hold_ok = 1'b0;
    end
    check("pause hold 50 ticks", hold_ok, 1'b1);
    check("pause bcd", bcd_a(), 16'h0130);
    bus_a.pausa = 1'b0;
    cycle();
    check("release valvula", bus_a.valvula, 4'b0001);
    check("release bcd", bcd_a(), 16'h0130);
    tick_a();
    check("after release tick", bcd_a(), 16'h0129);

    run_zone(4'b0001, 1'b1, n, asp_ok);
    check("zone0 ticks", 31 + n, 120);
    check("zone0 aspersao", asp_ok, 1'b1);
    check("gap0 valvula", bus_a.valvula, 4'b0000);
    check("gap0 bcd", bcd_a(), 16'h0000);
    check("gap0 ocupado", bus_a.ocupado, 1'b1);
    cycle();
    check("zone1 valvula", bus_a.valvula, 4'b0010);
    check("zone1 bcd", bcd_a(), 16'h0100);
    check("zone1 zona", bus_a.zonaAtiva, 3'd1);
    run_zone(4'b0010, 1'b0, n, asp_ok);
    check("zone1 ticks", n, 60);
    check("zone1 aspersao", asp_ok, 1'b1);
    check("gap1 valvula", bus_a.valvula, 4'b0000);
    cycle();
    check("zone3 valvula", bus_a.valvula, 4'b1000);
    check("zone3 zona", bus_a.zonaAtiva, 3'd3);
    run_zone(4'b1000, 1'b0, n, asp_ok);
    check("zone3 ticks", n, 60);
    check("last proxima fim", bus_a.fim, 1'b0);
    check("last proxima valvula", bus_a.valvula, 4'b0000);
    cycle();
    check("fim pulse", bus_a.fim, 1'b1);
    check("fim ocupado", bus_a.ocupado, 1'b0);
    cycle();
    check("fim falls", bus_a.fim, 1'b0);
    check("fim count seq", fim_count, 1);

    // Cancel during zone 1, and iniciar ignored while counting.
    bus_a.habilitaZona = 4'b0010;
    bus_a.modoZona     = 4'b0000;
    bus_a.iniciar      = 1'b1;
    cycle();
    bus_a.iniciar      = 1'b0;
    cycle();
    check("cancel zone1 open", bus_a.valvula, 4'b0010);
    repeat (3) tick_a();
    bus_a.iniciar = 1'b1;
    cycle();
    bus_a.iniciar = 1'b0;
    check("iniciar ignored bcd", bcd_a(), 16'h0057);
    check("iniciar ignored valvula", bus_a.valvula, 4'b0010);
    bus_a.parar = 1'b1;
    cycle();
    bus_a.parar = 1'b0;
    check("parar valvula", bus_a.valvula, 4'b0000);
    check("parar bcd", bcd_a(), 16'h0000);
    check("parar ocupado", bus_a.ocupado, 1'b0);
    check("parar fim", bus_a.fim, 1'b0);
    repeat (3) cycle();
    check("parar no fim pulse", fim_count, 1);

    // Cancel in PROXIMA.
    bus_a.iniciar = 1'b1;
    cycle();
    bus_a.iniciar = 1'b0;
    check("proxima ocupado", bus_a.ocupado, 1'b1);
    bus_a.parar = 1'b1;
    cycle();
    bus_a.parar = 1'b0;
    check("parar proxima ocupado", bus_a.ocupado, 1'b0);
    cycle();
    check("parar proxima valvula", bus_a.valvula, 4'b0000);

    // parar beats iniciar.
    bus_a.parar   = 1'b1;
    bus_a.iniciar = 1'b1;
    cycle();
    bus_a.parar   = 1'b0;
    bus_a.iniciar = 1'b0;
    check("parar+iniciar ocupado", bus_a.ocupado, 1'b0);
    cycle();
    check("parar+iniciar idle", bus_a.ocupado, 1'b0);
    check("parar+iniciar valvula", bus_a.valvula, 4'b0000);

    // Empty mask.
    bus_a.habilitaZona = 4'b0000;
    bus_a.iniciar      = 1'b1;
    cycle();
    bus_a.iniciar      = 1'b0;
    check("empty proxima fim", bus_a.fim, 1'b0);
    check("empty proxima valvula", bus_a.valvula, 4'b0000);
    cycle();
    check("empty fim", bus_a.fim, 1'b1);
    check("empty valvula", bus_a.valvula, 4'b0000);
    cycle();
    check("empty fim falls", bus_a.fim, 1'b0);
    check("fim count total", fim_count, 2);

    // Second instance: 10:00 drip borrow chain.
    bus_b.habilitaZona = 4'b0001;
    bus_b.modoZona     = 4'b0000;
    bus_b.iniciar      = 1'b1;
    cycle();
    bus_b.iniciar      = 1'b0;
    cycle();
    check("b load 10:00", bcd_b(), 16'h1000);
    bus_b.umSegundo = 1'b1;
    cycle();
    bus_b.umSegundo = 1'b0;
    check("b tick 09:59", bcd_b(), 16'h0959);
    bus_b.parar = 1'b1;
    cycle();
    bus_b.parar = 1'b0;

    // 13:00 sprinkler, 26 ticks down to 12:34 for the display.
    bus_b.modoZona = 4'b0001;
    bus_b.iniciar  = 1'b1;
    cycle();
    bus_b.iniciar  = 1'b0;
    cycle();
    check("b load 13:00", bcd_b(), 16'h1300);
    bus_b.umSegundo = 1'b1;
    repeat (26) cycle();
    bus_b.umSegundo = 1'b0;
    check("b bcd 12:34", bcd_b(), 16'h1234);

    for (int i = 0; i < 5; i++) begin
      check($sformatf("scan%0d digits", i), bus_b.displayDigits, telas[i].dig);
      check($sformatf("scan%0d segments", i), bus_b.displaySegments, telas[i].seg);
      bus_b.displayClock = 1'b1;
      cycle();
      bus_b.displayClock = 1'b0;
    end
    check("pre-reset digits", bus_b.displayDigits, 4'b1101);
    check("pre-reset valvula", bus_b.valvula, 4'b0001);

    // Asynchronous reset between edges.
    #2;
    resetN = 1'b0;
    #1;
    check("async digits", bus_b.displayDigits, 4'b1110);
    check("async segments", bus_b.displaySegments, 8'hC0);
    check("async valvula", bus_b.valvula, 4'b0000);
    check("async ocupado", bus_b.ocupado, 1'b0);
    #3;
    resetN = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporizador_irrigacao.md
# temporizador_irrigacao

Parametrised multi-zone irrigation countdown timer. On a start pulse it waters each enabled zone in ascending index order, one zone at a time, for that zone's mode duration (sprinkler or drip). It counts down a BCD mm:ss value on a one-second tick enable and drives the valve outputs and a 4-digit multiplexed 7-segment display. Everything runs in one clock domain; the one-second and display-scan rates arrive as single-cycle enables from the board's prescaler.

## Interface
- NUM_ZONAS, 4: zone count, legal range 2..8.
- PRESET_ASPERSAO_MIN, 51: sprinkler duration in whole minutes, 1..59.
- PRESET_GOTEJAMENTO_MIN, 3: drip duration in whole minutes, 1..59.

- clock  in  1  system clock; all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- umSegundo  in  1  one-cycle enable, once per second.
- displayClock  in  1  one-cycle enable, advances digit scan.
- iniciar  in  1  start pulse.
- parar  in  1  cancel pulse.
- pausa  in  1  level; holds countdown.
- habilitaZona  in  NUM_ZONAS  zone enable mask.
- modoZona  in  NUM_ZONAS  per-zone mode, 1 = sprinkler, 0 = drip.
- dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos  out  4 each  BCD remaining time.
- valvula  out  NUM_ZONAS  one-hot open valve.
- aspersaoAtiva  out  1  active zone is in sprinkler mode.
- zonaAtiva  out  3  index of the current zone.
- ocupado  out  1  sequence in progress.
- fim  out  1  one-cycle pulse when the sequence ends.
- displayDigits  out  4  active-low digit select.
- displaySegments  out  8  active-low {dp,g,f,e,d,c,b,a}.

## Operation
- **States:** OCIOSO, PROXIMA, CONTANDO, PAUSADO, CONCLUIDO.
- **OCIOSO:**
  - On iniciar: latch habilitaZona and modoZona, set zone pointer to -1, go to PROXIMA.
- **PROXIMA (1 cycle):**
  - Select the lowest enabled zone with index above the pointer.
  - If one exists: load BCD with that zone's preset as mm:00, set zonaAtiva, go to CONTANDO.
  - If none exists: go to CONCLUIDO.
- **CONTANDO:**
  - valvula[zonaAtiva] = 1; aspersaoAtiva = latched mode of that zone.
  - On umSegundo: BCD decrement with borrow chain. unidadeSegundos wraps 0→9, dezenaSegundos wraps 0→5, unidadeMinuto wraps 0→9, then dezenaMinuto decrements.
  - On the tick that takes 00:01 to 00:00: go to PROXIMA on the same edge.
  - pausa = 1: go to PAUSADO.
- **PAUSADO:**
  - Valves closed; count frozen; umSegundo ignored.
  - pausa = 0: return to CONTANDO.
- **CONCLUIDO (1 cycle):** fim = 1, then go to OCIOSO.
- **parar:** from any state, go to OCIOSO next edge. Valves close, BCD clears to 00:00, no fim pulse.
- **Priorities and ignored inputs:**
  - parar beats iniciar.
  - pausa beats umSegundo in the same cycle.
  - iniciar outside OCIOSO is ignored.
  - umSegundo in PROXIMA is ignored.
- **Mask handling:**
  - Mask changes during a sequence have no effect.
  - An empty mask at start goes OCIOSO→PROXIMA→CONCLUIDO: fim pulses, no valve opens.
- ocupado = 1 in PROXIMA, CONTANDO and PAUSADO.
- **Display:**
  - 2-bit scan index increments, wrapping, on displayClock.
  - Index 0..3 shows unidadeSegundos, dezenaSegundos, unidadeMinuto, dezenaMinuto; displayDigits bit i is low when index = i.
  - dp is lit only on index 2, as the mm.ss separator.
  - Standard 0–9 glyphs; codes 10–15 blank all segments.

## Timing
- **Reset values:**
  - state OCIOSO, BCD 0000, valvula 0, aspersaoAtiva 0, zonaAtiva 0, ocupado 0, fim 0.
  - Scan index 0, so displayDigits = 4'b1110 and displaySegments = 8'b11000000.
- **Start latency:** iniciar at edge N gives PROXIMA at N+1 and CONTANDO with the valve open at N+2.
- **Zone length:** exactly preset×60 umSegundo ticks while CONTANDO, plus one clock in PROXIMA between zones. During that PROXIMA clock all valves are closed.
- **Sequence end:** fim is high for exactly one clock, the cycle after the last zone's PROXIMA. ocupado falls on the same edge fim rises.
- **Cancel:** outputs are registered; parar takes effect one edge later, including mid-PROXIMA.
- **Reset mid-operation:** valves close immediately and asynchronously.

## Test plan
- NUM_ZONAS=4, PRESET_ASPERSAO_MIN=2, PRESET_GOTEJAMENTO_MIN=1; habilitaZona=1011, modoZona=0001, tick every 4 clocks.
  - Required: zone 0 open for 120 ticks with aspersaoAtiva=1.
  - Then zone 1 for 60 ticks, zone 3 for 60 ticks, then a single fim pulse.
- Decrement chain from load 02:00: one tick → 01:59. Load 10:00 via a 10-minute preset, one tick → 09:59.
- Pause at 01:30 for 50 ticks:
  - valvula=0 and BCD holds 01:30.
  - After release, the next tick gives 01:29.
  - Tick and pausa asserted in the same cycle do not decrement.
- parar during zone 1: next edge gives valvula=0, BCD 00:00, ocupado=0, fim never pulses. parar with iniciar in the same cycle keeps state OCIOSO.
- habilitaZona=0000 then iniciar: fim pulses 2 clocks later and valvula stays 0 throughout.
- Display:
  - BCD 12:34, 4 displayClock enables: digits 1110→1101→1011→0111.
  - Segments 4, 3, 2 with dp low, then 1.
  - Assert resetN=0 mid-scan: output returns to 1110/11000000 asynchronously.
